csr_commit_seq: RTL and testbench
=================================

Name: csr_commit_seq

Overview:
Sequences CSR instructions at the ROB head through a read–modify–write of the CSR file. It computes the new CSR value, writes back the old value to the issue queue/RAT, and signals the ROB to retire the entry. It sits between the ROB commit port, the CSR register file and the writeback bus. Exactly one CSR instruction is in flight at a time.

Parameters:
WORD_WIDTH, 32, data width of CSRs and GPRs
ROB_DEPTH, 16, ROB entries; Paddr width is $clog2(ROB_DEPTH)
CSR_ADDR_WIDTH, 12, CSR address width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
rob_head_valid  input  1  ROB head entry valid and ready to commit
rob_head_csr_op  input  3  op: 0 NOP, 1 CSRRW, 2 CSRRS, 3 CSRRC, 4 CSRRWI, 5 CSRRSI, 6 CSRRCI, 7 ECALL_EBREAK
rob_head_csr_addr  input  CSR_ADDR_WIDTH  target CSR
rob_head_rs1_data  input  WORD_WIDTH  x[rs1] value
rob_head_uimm  input  5  zimm field, also used as the rs1 index
rob_head_rd_en  input  1  rd != x0
rob_head_Paddr  input  $clog2(ROB_DEPTH)  destination physical tag
rob_flush  input  1  pipeline flush
csr_rd_addr  output  CSR_ADDR_WIDTH  CSR read address
csr_rd_data  input  WORD_WIDTH  combinational CSR read data
csr_we  output  1  CSR write strobe
csr_w_addr  output  CSR_ADDR_WIDTH  CSR write address
csr_w_data  output  WORD_WIDTH  CSR write data
wb_csr_valid  output  1  writeback strobe
wb_csr_data  output  WORD_WIDTH  old CSR value
wb_csr_dst_Paddr  output  $clog2(ROB_DEPTH)  writeback tag
csr_commit_done  output  1  one-cycle retire pulse to the ROB
csr_busy  output  1  sequencer not IDLE; the ROB stalls its commit

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0, all capture registers 0.
- States: IDLE, READ, WRITE, DONE.
- IDLE → READ when rob_head_valid=1 and op is in 1..6 and rob_flush=0.
  - In that cycle, capture op, addr, rs1_data, uimm, rd_en and Paddr.
  - Ops 0 and 7 are ignored; state stays IDLE.
- READ (1 cycle):
  - csr_rd_addr = captured addr.
  - Register csr_rd_data into old_val at the cycle end.
  - Go to WRITE.
- WRITE (1 cycle):
  - new value:
    - RW: rs1
    - RS: old | rs1
    - RC: old & ~rs1
    - RWI: {27'b0, uimm}
    - RSI: old | {27'b0, uimm}
    - RCI: old & ~{27'b0, uimm}
  - csr_w_addr = addr and csr_w_data = new value, both combinational from registers.
  - csr_we=1, except for RS/RC/RSI/RCI with uimm==0. Those perform no write, per RISC-V x0/zero-immediate rule.
  - wb_csr_valid = rd_en, wb_csr_data = old_val, wb_csr_dst_Paddr = Paddr.
  - Go to DONE.
- DONE: csr_commit_done=1 for exactly one cycle, then IDLE.
  - A new CSR op at the ROB head is accepted no earlier than the cycle after DONE.
- csr_busy = (state != IDLE).
- Latency: acceptance at cycle N gives READ at N+1, WRITE at N+2 and done at N+3. Back-to-back CSR ops start 4 cycles apart.
- Outside their states, csr_rd_addr, csr_w_addr, csr_w_data, wb_csr_data and wb_csr_dst_Paddr are 0.
- rob_flush has priority in every state:
  - The next state is IDLE.
  - In the flush cycle csr_we, wb_csr_valid and csr_commit_done are forced to 0.
  - A flush during WRITE cancels the write, so the CSR is unchanged.
- Reset asserted mid-operation: immediate return to IDLE with outputs 0; no partial write.
- Arithmetic is WORD_WIDTH-wide bitwise only; no carries.

Test Plan:
- CSRRW, addr 0x305, rs1 0xDEAD_BEEF, old 0x0000_0100, rd_en=1, Paddr 5 → at N+2: csr_we=1, w_data 0xDEADBEEF, wb_csr_valid=1, wb_data 0x100, Paddr 5; done pulse at N+3; busy high N+1..N+3.
- CSRRS, rs1 0x0F, old 0xF0 → w_data 0xFF. CSRRC, rs1 0x0F, old 0xFF → w_data 0xF0.
- CSRRSI with uimm=0, old 0x1234, rd_en=1 → csr_we=0, wb_csr_valid=1, wb_data 0x1234, done pulse. CSRRCI uimm 0x1F, old 0xFFFF_FFFF → w_data 0xFFFF_FFE0.
- CSRRWI uimm 0x15, rd_en=0 → csr_we=1, w_data 0x15, wb_csr_valid=0, done pulse.
- rob_flush asserted in the WRITE cycle → csr_we=0, wb_csr_valid=0, no done pulse, state IDLE next cycle. Repeat the flush in READ with the same result.
- Ops NOP and ECALL_EBREAK held at the head for 5 cycles → busy=0 and no strobes. rst pulse during READ → all outputs 0 asynchronously; the next CSR op is accepted normally.

Source files
------------

// File: rtl/csr_commit_seq.sv
// CSR commit sequencer: performs the read-modify-write of one CSR instruction
// at the ROB head, returns the old value on the writeback bus and retires it.
module csr_commit_seq #(
    parameter int WORD_WIDTH     = 32,
    parameter int ROB_DEPTH      = 16,
    parameter int CSR_ADDR_WIDTH = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rob_head_valid,
    input  logic [2:0]                   rob_head_csr_op,
    input  logic [CSR_ADDR_WIDTH-1:0]    rob_head_csr_addr,
    input  logic [WORD_WIDTH-1:0]        rob_head_rs1_data,
    input  logic [4:0]                   rob_head_uimm,
    input  logic                         rob_head_rd_en,
    input  logic [$clog2(ROB_DEPTH)-1:0] rob_head_Paddr,
    input  logic                         rob_flush,
    output logic [CSR_ADDR_WIDTH-1:0]    csr_rd_addr,
    input  logic [WORD_WIDTH-1:0]        csr_rd_data,
    output logic                         csr_we,
    output logic [CSR_ADDR_WIDTH-1:0]    csr_w_addr,
    output logic [WORD_WIDTH-1:0]        csr_w_data,
    output logic                         wb_csr_valid,
    output logic [WORD_WIDTH-1:0]        wb_csr_data,
    output logic [$clog2(ROB_DEPTH)-1:0] wb_csr_dst_Paddr,
    output logic                         csr_commit_done,
    output logic                         csr_busy
);

    localparam int PADDR_W = $clog2(ROB_DEPTH);

    localparam logic [2:0] OP_RW  = 3'd1;
    localparam logic [2:0] OP_RS  = 3'd2;
    localparam logic [2:0] OP_RC  = 3'd3;
    localparam logic [2:0] OP_RWI = 3'd4;
    localparam logic [2:0] OP_RSI = 3'd5;
    localparam logic [2:0] OP_RCI = 3'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                      state;
    logic [2:0]                  op_q;
    logic [CSR_ADDR_WIDTH-1:0]   addr_q;
    logic [WORD_WIDTH-1:0]       rs1_q;
    logic [4:0]                  uimm_q;
    logic                        rd_en_q;
    logic [PADDR_W-1:0]          paddr_q;
    logic [WORD_WIDTH-1:0]       old_q;

    logic                        accept;
    logic [WORD_WIDTH-1:0]       uimm_ext;
    logic [WORD_WIDTH-1:0]       new_val;
    logic                        write_skip;

    assign accept = rob_head_valid && !rob_flush &&
                    (rob_head_csr_op >= OP_RW) && (rob_head_csr_op <= OP_RCI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            rs1_q   <= '0;
            uimm_q  <= '0;
            rd_en_q <= 1'b0;
            paddr_q <= '0;
            old_q   <= '0;
        end else if (rob_flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= rob_head_csr_op;
                        addr_q  <= rob_head_csr_addr;
                        rs1_q   <= rob_head_rs1_data;
                        uimm_q  <= rob_head_uimm;
                        rd_en_q <= rob_head_rd_en;
                        paddr_q <= rob_head_Paddr;
                        state   <= READ;
                    end
                end
                READ: begin
                    old_q <= csr_rd_data;
                    state <= WRITE;
                end
                WRITE:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign uimm_ext = {{(WORD_WIDTH-5){1'b0}}, uimm_q};

    always_comb begin
        new_val = old_q;
        case (op_q)
            OP_RW:   new_val = rs1_q;
            OP_RS:   new_val = old_q | rs1_q;
            OP_RC:   new_val = old_q & ~rs1_q;
            OP_RWI:  new_val = uimm_ext;
            OP_RSI:  new_val = old_q | uimm_ext;
            OP_RCI:  new_val = old_q & ~uimm_ext;
            default: new_val = old_q;
        endcase
    end

    // Set/clear forms with rs1 = x0 (or zimm = 0) must not touch the CSR,
    // which matters for CSRs with write side effects.
    assign write_skip = (op_q == OP_RS) || (op_q == OP_RC) ||
                        (op_q == OP_RSI) || (op_q == OP_RCI) ? (uimm_q == 5'd0) : 1'b0;

    always_comb begin
        csr_rd_addr      = '0;
        csr_we           = 1'b0;
        csr_w_addr       = '0;
        csr_w_data       = '0;
        wb_csr_valid     = 1'b0;
        wb_csr_data      = '0;
        wb_csr_dst_Paddr = '0;
        csr_commit_done  = 1'b0;
        csr_busy         = (state != IDLE);
        case (state)
            READ: csr_rd_addr = addr_q;
            WRITE: begin
                csr_w_addr       = addr_q;
                csr_w_data       = new_val;
                csr_we           = !write_skip && !rob_flush;
                wb_csr_valid     = rd_en_q && !rob_flush;
                wb_csr_data      = old_q;
                wb_csr_dst_Paddr = paddr_q;
            end
            DONE: csr_commit_done = !rob_flush;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_commit_seq.sv
// Bench for csr_commit_seq: timeline reference model of expected per-cycle
// outputs, a CSR file driven by the DUT, directed cases plus random traffic.
module tb_csr_commit_seq;

    logic        clk;
    logic        rst;
    logic        rob_head_valid;
    logic [2:0]  rob_head_csr_op;
    logic [11:0] rob_head_csr_addr;
    logic [31:0] rob_head_rs1_data;
    logic [4:0]  rob_head_uimm;
    logic        rob_head_rd_en;
    logic [3:0]  rob_head_Paddr;
    logic        rob_flush;
    logic [11:0] csr_rd_addr;
    logic [31:0] csr_rd_data;
    logic        csr_we;
    logic [11:0] csr_w_addr;
    logic [31:0] csr_w_data;
    logic        wb_csr_valid;
    logic [31:0] wb_csr_data;
    logic [3:0]  wb_csr_dst_Paddr;
    logic        csr_commit_done;
    logic        csr_busy;

    csr_commit_seq dut (
        .clk               (clk),
        .rst               (rst),
        .rob_head_valid    (rob_head_valid),
        .rob_head_csr_op   (rob_head_csr_op),
        .rob_head_csr_addr (rob_head_csr_addr),
        .rob_head_rs1_data (rob_head_rs1_data),
        .rob_head_uimm     (rob_head_uimm),
        .rob_head_rd_en    (rob_head_rd_en),
        .rob_head_Paddr    (rob_head_Paddr),
        .rob_flush         (rob_flush),
        .csr_rd_addr       (csr_rd_addr),
        .csr_rd_data       (csr_rd_data),
        .csr_we            (csr_we),
        .csr_w_addr        (csr_w_addr),
        .csr_w_data        (csr_w_data),
        .wb_csr_valid      (wb_csr_valid),
        .wb_csr_data       (wb_csr_data),
        .wb_csr_dst_Paddr  (wb_csr_dst_Paddr),
        .csr_commit_done   (csr_commit_done),
        .csr_busy          (csr_busy)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // CSR file seen by the DUT; cleared by reset.
    logic [31:0] csr_mem [0:4095];
    assign csr_rd_data = csr_mem[csr_rd_addr];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) csr_mem[i] <= '0;
        end else if (csr_we) begin
            csr_mem[csr_w_addr] <= csr_w_data;
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        busy;
        logic [11:0] rd_addr;
        logic        we;
        logic [11:0] w_addr;
        logic [31:0] w_data;
        logic        wb_valid;
        logic [31:0] wb_data;
        logic [3:0]  paddr;
        logic        done;
    } exp_t;

    exp_t        exp_tab [int];
    logic [31:0] ref_csr [int];
    int          cyc;
    int          n_cmp;
    int          n_bad;

    logic [11:0] obs_rd_addr;
    logic        obs_we, obs_wbv, obs_done, obs_busy;
    logic [31:0] obs_wdata, obs_wbd;
    logic [3:0]  obs_pad;

    function automatic logic [31:0] ref_get(input logic [11:0] a);
        return ref_csr.exists(int'(a)) ? ref_csr[int'(a)] : 32'h0;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    // Ops 1..6 split into write/set/clear on either rs1 or the zero-extended zimm.
    function automatic void schedule(input int c, input logic [2:0] op, input logic [11:0] addr,
                                     input logic [31:0] rs1, input logic [4:0] uimm,
                                     input logic rd_en, input logic [3:0] pad);
        exp_t        r, w, d;
        logic [31:0] old, src, nv;
        int          kind;
        old  = ref_get(addr);
        src  = (op >= 3'd4) ? {27'b0, uimm} : rs1;
        kind = (int'(op) - 1) % 3;
        nv   = (kind == 0) ? src : (kind == 1) ? (old | src) : (old & ~src);
        r = '0; r.busy = 1'b1; r.rd_addr = addr;
        w = '0; w.busy = 1'b1; w.w_addr = addr; w.w_data = nv;
        w.we = (kind == 0) || (uimm != 5'd0);
        w.wb_valid = rd_en; w.wb_data = old; w.paddr = pad;
        d = '0; d.busy = 1'b1; d.done = 1'b1;
        exp_tab[c+1] = r;
        exp_tab[c+2] = w;
        exp_tab[c+3] = d;
    endfunction

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic v, input logic [2:0] op, input logic [11:0] addr,
                               input logic [31:0] rs1, input logic [4:0] uimm,
                               input logic rd_en, input logic [3:0] pad, input logic fl);
        exp_t e;
        @(posedge clk); #1;
        rob_head_valid    = v;
        rob_head_csr_op   = op;
        rob_head_csr_addr = addr;
        rob_head_rs1_data = rs1;
        rob_head_uimm     = uimm;
        rob_head_rd_en    = rd_en;
        rob_head_Paddr    = pad;
        rob_flush         = fl;
        @(negedge clk);
        cyc++;
        e = exp_tab.exists(cyc) ? exp_tab[cyc] : '0;
        if (fl) begin
            e.we = 1'b0; e.wb_valid = 1'b0; e.done = 1'b0;
            for (int k = 1; k <= 3; k++) if (exp_tab.exists(cyc + k)) exp_tab.delete(cyc + k);
        end
        chk("csr_busy",         32'(csr_busy),         32'(e.busy));
        chk("csr_rd_addr",      32'(csr_rd_addr),      32'(e.rd_addr));
        chk("csr_we",           32'(csr_we),           32'(e.we));
        chk("csr_w_addr",       32'(csr_w_addr),       32'(e.w_addr));
        chk("csr_w_data",       csr_w_data,            e.w_data);
        chk("wb_csr_valid",     32'(wb_csr_valid),     32'(e.wb_valid));
        chk("wb_csr_data",      wb_csr_data,           e.wb_data);
        chk("wb_csr_dst_Paddr", 32'(wb_csr_dst_Paddr), 32'(e.paddr));
        chk("csr_commit_done",  32'(csr_commit_done),  32'(e.done));
        obs_rd_addr = csr_rd_addr; obs_we = csr_we; obs_wdata = csr_w_data;
        obs_wbv = wb_csr_valid; obs_wbd = wb_csr_data; obs_pad = wb_csr_dst_Paddr;
        obs_done = csr_commit_done; obs_busy = csr_busy;
        if (e.we) ref_csr[int'(e.w_addr)] = e.w_data;
        if (!e.busy && v && op >= 3'd1 && op <= 3'd6 && !fl)
            schedule(cyc, op, addr, rs1, uimm, rd_en, pad);
        if (exp_tab.exists(cyc)) exp_tab.delete(cyc);
    endtask

    task automatic idle_cycle(input logic fl);
        drive_cycle(1'b0, 3'd0, 12'h0, 32'h0, 5'd0, 1'b0, 4'd0, fl);
    endtask

    // Results of the last run_op, one slot per phase after acceptance.
    logic        r_busy1, r_busy2, r_busy3, r_busy4, r_we, r_wbv, r_done;
    logic [11:0] r_rd_addr;
    logic [31:0] r_wdata, r_wbd;
    logic [3:0]  r_pad;

    task automatic run_op(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] rs1,
                          input logic [4:0] uimm, input logic rd_en, input logic [3:0] pad,
                          input int flush_at);
        drive_cycle(1'b1, op, addr, rs1, uimm, rd_en, pad, 1'b0);
        idle_cycle(flush_at == 1);
        r_busy1 = obs_busy; r_rd_addr = obs_rd_addr;
        idle_cycle(flush_at == 2);
        r_busy2 = obs_busy; r_we = obs_we; r_wdata = obs_wdata;
        r_wbv = obs_wbv; r_wbd = obs_wbd; r_pad = obs_pad;
        idle_cycle(1'b0);
        r_busy3 = obs_busy; r_done = obs_done;
        idle_cycle(1'b0);
        r_busy4 = obs_busy;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  32'(csr_busy), 32'h0);
        chk({tag, "_rdad"},  32'(csr_rd_addr), 32'h0);
        chk({tag, "_we"},    32'(csr_we), 32'h0);
        chk({tag, "_wad"},   32'(csr_w_addr), 32'h0);
        chk({tag, "_wdat"},  csr_w_data, 32'h0);
        chk({tag, "_wbv"},   32'(wb_csr_valid), 32'h0);
        chk({tag, "_wbd"},   wb_csr_data, 32'h0);
        chk({tag, "_pad"},   32'(wb_csr_dst_Paddr), 32'h0);
        chk({tag, "_done"},  32'(csr_commit_done), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        rst = 1'b0;
        rob_head_valid = 1'b0; rob_head_csr_op = 3'd0; rob_head_csr_addr = '0;
        rob_head_rs1_data = '0; rob_head_uimm = '0; rob_head_rd_en = 1'b0;
        rob_head_Paddr = '0; rob_flush = 1'b0;
        #2 rst = 1'b1;
        #1 check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // CSRRW with old value 0x100 set up by a previous CSRRW
        run_op(3'd1, 12'h305, 32'h0000_0100, 5'd3, 1'b0, 4'd0, 0);
        run_op(3'd1, 12'h305, 32'hDEAD_BEEF, 5'd7, 1'b1, 4'd5, 0);
        chk("rw_busy1", 32'(r_busy1), 32'h1);
        chk("rw_rdaddr", 32'(r_rd_addr), 32'h305);
        chk("rw_busy2", 32'(r_busy2), 32'h1);
        chk("rw_we", 32'(r_we), 32'h1);
        chk("rw_wdata", r_wdata, 32'hDEAD_BEEF);
        chk("rw_wbv", 32'(r_wbv), 32'h1);
        chk("rw_wbd", r_wbd, 32'h0000_0100);
        chk("rw_pad", 32'(r_pad), 32'h5);
        chk("rw_done", 32'(r_done), 32'h1);
        chk("rw_busy3", 32'(r_busy3), 32'h1);
        chk("rw_busy4", 32'(r_busy4), 32'h0);
        chk("rw_mem", csr_mem[12'h305], 32'hDEAD_BEEF);

        // CSRRS / CSRRC
        run_op(3'd1, 12'h300, 32'h0000_00F0, 5'd1, 1'b0, 4'd0, 0);
        run_op(3'd2, 12'h300, 32'h0000_000F, 5'd1, 1'b1, 4'd2, 0);
        chk("rs_wdata", r_wdata, 32'h0000_00FF);
        chk("rs_wbd", r_wbd, 32'h0000_00F0);
        run_op(3'd3, 12'h300, 32'h0000_000F, 5'd1, 1'b1, 4'd3, 0);
        chk("rc_wdata", r_wdata, 32'h0000_00F0);
        chk("rc_we", 32'(r_we), 32'h1);

        // CSRRSI with zimm 0 performs no write but still writes back
        run_op(3'd1, 12'h340, 32'h0000_1234, 5'd1, 1'b0, 4'd0, 0);
        run_op(3'd5, 12'h340, 32'hFFFF_FFFF, 5'd0, 1'b1, 4'd9, 0);
        chk("rsi0_we", 32'(r_we), 32'h0);
        chk("rsi0_wbv", 32'(r_wbv), 32'h1);
        chk("rsi0_wbd", r_wbd, 32'h0000_1234);
        chk("rsi0_done", 32'(r_done), 32'h1);

        run_op(3'd1, 12'h341, 32'hFFFF_FFFF, 5'd1, 1'b0, 4'd0, 0);
        run_op(3'd6, 12'h341, 32'h0, 5'h1F, 1'b1, 4'd1, 0);
        chk("rci_wdata", r_wdata, 32'hFFFF_FFE0);

        run_op(3'd4, 12'h342, 32'hFFFF_FFFF, 5'h15, 1'b0, 4'd4, 0);
        chk("rwi_we", 32'(r_we), 32'h1);
        chk("rwi_wdata", r_wdata, 32'h0000_0015);
        chk("rwi_wbv", 32'(r_wbv), 32'h0);
        chk("rwi_done", 32'(r_done), 32'h1);

        // Flush in WRITE, then in READ
        run_op(3'd1, 12'h342, 32'hAAAA_5555, 5'd1, 1'b1, 4'd6, 2);
        chk("flw_we", 32'(r_we), 32'h0);
        chk("flw_wbv", 32'(r_wbv), 32'h0);
        chk("flw_done", 32'(r_done), 32'h0);
        chk("flw_busy3", 32'(r_busy3), 32'h0);
        chk("flw_mem", csr_mem[12'h342], 32'h0000_0015);
        run_op(3'd1, 12'h342, 32'hAAAA_5555, 5'd1, 1'b1, 4'd6, 1);
        chk("flr_we", 32'(r_we), 32'h0);
        chk("flr_wbv", 32'(r_wbv), 32'h0);
        chk("flr_done", 32'(r_done), 32'h0);
        chk("flr_busy2", 32'(r_busy2), 32'h0);
        chk("flr_mem", csr_mem[12'h342], 32'h0000_0015);

        // NOP and ECALL/EBREAK at the head are ignored
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, (i < 5) ? 3'd0 : 3'd7, 12'h300, 32'hFFFF_FFFF, 5'd9, 1'b1, 4'd7, 1'b0);
            chk("nop_busy", 32'(obs_busy), 32'h0);
            chk("nop_we", 32'(obs_we | obs_wbv | obs_done), 32'h0);
        end

        // Asynchronous reset while in READ
        drive_cycle(1'b1, 3'd1, 12'h305, 32'h1357_9BDF, 5'd1, 1'b1, 4'd8, 1'b0);
        idle_cycle(1'b0);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        ref_csr.delete();
        exp_tab.delete();
        @(posedge clk); #1 rst = 1'b0;
        run_op(3'd4, 12'h305, 32'h0, 5'h0A, 1'b1, 4'd3, 0);
        chk("postrst_wdata", r_wdata, 32'h0000_000A);
        chk("postrst_wbd", r_wbd, 32'h0);
        chk("postrst_done", 32'(r_done), 32'h1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [4:0] u;
            u = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            drive_cycle($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
                        12'h300 + 12'($urandom_range(0, 3)), $urandom, u,
                        1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 4; i++) idle_cycle(1'b0);
        for (int a = 12'h300; a < 12'h304; a++)
            chk("final_csr", csr_mem[a], ref_get(12'(a)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
